// File: rtl/wload_ctrl.sv
// Weight-load sequencer: fetches WLC_NUM_WREG words from memory and strobes them into weight registers.
// Define WLC_CLEAR_EN to add a one-cycle clear of all weight registers before the first fetch.
module wload_ctrl #(
    parameter int WLC_DATA_WIDTH = 8,
    parameter int WLC_NUM_WREG   = 9,
    parameter int WLC_ADDR_WIDTH = 10
) (
    input  logic                      WLC_Clk,
    input  logic                      WLC_Reset,
    input  logic                      WLC_Start,
    input  logic [WLC_ADDR_WIDTH-1:0] WLC_Base_Addr,
    input  logic                      WLC_Mem_Ack,
    input  logic [WLC_DATA_WIDTH-1:0] WLC_Mem_Data,
    output logic                      WLC_Mem_Req,
    output logic [WLC_ADDR_WIDTH-1:0] WLC_Mem_Addr,
    output logic [WLC_NUM_WREG-1:0]   WLC_Set,
    output logic [WLC_DATA_WIDTH-1:0] WLC_Wdata,
    output logic                      WLC_Clear,
    output logic                      WLC_Busy,
    output logic                      WLC_Done
);

    localparam int IDX_W = $clog2(WLC_NUM_WREG);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WLC_NUM_WREG - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
`ifdef WLC_CLEAR_EN
        S_CLEAR = 3'd1,
`endif
        S_REQ   = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                    state, state_nxt;
    logic [IDX_W-1:0]          idx, idx_nxt;
    logic [WLC_ADDR_WIDTH-1:0] base, base_nxt;
    logic [WLC_DATA_WIDTH-1:0] wdata_nxt;
    logic [WLC_ADDR_WIDTH-1:0] addr_nxt;
    logic [WLC_NUM_WREG-1:0]   set_nxt;
    logic                      clear_nxt;

    always_ff @(posedge WLC_Clk or posedge WLC_Reset) begin
        if (WLC_Reset) begin
            state <= S_IDLE;
            idx   <= '0;
            base  <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            base  <= base_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        base_nxt  = base;
        wdata_nxt = WLC_Wdata;
        case (state)
            S_IDLE: begin
                if (WLC_Start) begin
                    base_nxt = WLC_Base_Addr;
                    idx_nxt  = '0;
`ifdef WLC_CLEAR_EN
                    state_nxt = S_CLEAR;
`else
                    state_nxt = S_REQ;
`endif
                end
            end
`ifdef WLC_CLEAR_EN
            S_CLEAR: state_nxt = S_REQ;
`endif
            S_REQ: begin
                if (WLC_Mem_Ack) begin
                    wdata_nxt = WLC_Mem_Data;
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (idx == LAST_IDX) begin
                    state_nxt = S_DONE;
                end else begin
                    idx_nxt   = idx + 1'b1;
                    state_nxt = S_REQ;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // Outputs are decoded from the next state so that they appear registered in the state they describe.
        addr_nxt = (state_nxt == S_REQ) ? base_nxt + WLC_ADDR_WIDTH'(idx_nxt) : WLC_Mem_Addr;
        set_nxt  = '0;
        if (state_nxt == S_WRITE) begin
            set_nxt[idx_nxt] = 1'b1;
        end
`ifdef WLC_CLEAR_EN
        clear_nxt = (state_nxt == S_CLEAR);
`else
        clear_nxt = 1'b0;
`endif
    end

    always_ff @(posedge WLC_Clk or posedge WLC_Reset) begin
        if (WLC_Reset) begin
            WLC_Mem_Req  <= 1'b0;
            WLC_Mem_Addr <= '0;
            WLC_Set      <= '0;
            WLC_Wdata    <= '0;
            WLC_Clear    <= 1'b0;
            WLC_Busy     <= 1'b0;
            WLC_Done     <= 1'b0;
        end else begin
            WLC_Mem_Req  <= (state_nxt == S_REQ);
            WLC_Mem_Addr <= addr_nxt;
            WLC_Set      <= set_nxt;
            WLC_Wdata    <= wdata_nxt;
            WLC_Clear    <= clear_nxt;
            WLC_Busy     <= (state_nxt != S_IDLE);
            WLC_Done     <= (state_nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_wload_ctrl.sv
// Self-checking bench for wload_ctrl: scoreboard of weight loads plus directed scenarios.
// Latency is counted as the number of rising edges from the Start sample edge to the first edge that samples Done high.
module tb_wload_ctrl;

    localparam int NW = 9;
    localparam int AW = 10;
    localparam int DW = 8;
`ifdef WLC_CLEAR_EN
    localparam int CLR = 1;
`else
    localparam int CLR = 0;
`endif

    logic          tb_clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base;
    logic          ack;
    logic [DW-1:0] mdata;
    logic          req;
    logic [AW-1:0] addr;
    logic [NW-1:0] set;
    logic [DW-1:0] wdata;
    logic          clear;
    logic          busy;
    logic          done;

    wload_ctrl #(
        .WLC_DATA_WIDTH(DW),
        .WLC_NUM_WREG  (NW),
        .WLC_ADDR_WIDTH(AW)
    ) dut (
        .WLC_Clk      (tb_clk),
        .WLC_Reset    (rst),
        .WLC_Start    (start),
        .WLC_Base_Addr(base),
        .WLC_Mem_Ack  (ack),
        .WLC_Mem_Data (mdata),
        .WLC_Mem_Req  (req),
        .WLC_Mem_Addr (addr),
        .WLC_Set      (set),
        .WLC_Wdata    (wdata),
        .WLC_Clear    (clear),
        .WLC_Busy     (busy),
        .WLC_Done     (done)
    );

    always #5 tb_clk = ~tb_clk;

    // Memory returns the low byte of the requested address.
    assign mdata = addr[7:0];

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    int edge_n = 0;
    always @(posedge tb_clk) edge_n <= edge_n + 1;

    // Handshake from stimulus to scoreboard (stimulus writes, scoreboard reads).
    int            start_seq = 0;
    int            abort_seq = 0;
    logic [AW-1:0] st_base = '0;
    int            st_edge = 0;
    bit            st_tied = 1'b0;
    int            ack_delay = 0;

    // Scoreboard state (written only by the compare process).
    int            seen_start = 0;
    int            seen_abort = 0;
    bit            m_active = 1'b0;
    int            m_k = 0;
    logic [AW-1:0] m_base = '0;
    int            m_start_edge = 0;
    bit            m_tied = 1'b0;
    int            m_dones = 0;
    int            m_lat = 0;
    bit            prev_ack_req = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] wd_log [32];
    logic [AW-1:0] ad_log [32];

    always @(negedge tb_clk) begin
        if (abort_seq != seen_abort) begin
            seen_abort = abort_seq;
            m_active   = 1'b0;
            m_k        = 0;
        end
        if (start_seq != seen_start) begin
            seen_start   = start_seq;
            m_active     = 1'b1;
            m_k          = 0;
            m_base       = st_base;
            m_start_edge = st_edge;
            m_tied       = st_tied;
            m_dones      = 0;
        end
        if (rst) begin
            check("rst_outputs", {req, addr, set, wdata, clear, busy, done}, 32'd0);
            prev_ack_req = 1'b0;
        end else begin
            check("busy", busy, m_active);
            check("set_onehot0", $onehot0(set), 1);
            check("set_clear_excl", (set != 0) && clear, 0);
            check("clear", clear, (CLR != 0) && m_active && (edge_n == m_start_edge));
            if (!m_active) check("idle_quiet", {req, set, done}, 0);
            if (m_active && edge_n == m_start_edge) check("req_after_start", req, CLR == 0);
            if (req) begin
                check("mem_addr", addr, AW'(m_base + m_k));
                last_addr = addr;
            end
            if (set != 0) begin
                check("set_bit", set, NW'(1) << m_k);
                check("set_after_ack", prev_ack_req, 1);
                check("wdata", wdata, DW'(m_base + m_k));
                if (m_k < 32) begin
                    wd_log[m_k] = wdata;
                    ad_log[m_k] = last_addr;
                end
                m_k++;
            end
            if (done) begin
                check("done_active", m_active, 1);
                check("done_weights", m_k, NW);
                check("done_wdata_hold", wdata, DW'(m_base + NW - 1));
                m_lat = edge_n - m_start_edge + 1;
                if (m_tied) check("latency", m_lat, 2 * NW + 1 + CLR);
                m_dones++;
                m_active = 1'b0;
            end
            prev_ack_req = ack && req;
        end
    end

    // Memory responder: ack tied high, or raised after ack_delay cycles of pending request.
    initial begin
        int req_cnt;
        req_cnt = 0;
        ack = 1'b0;
        forever begin
            @(posedge tb_clk);
            #2;
            if (ack_delay == 0) begin
                ack = 1'b1;
            end else if (req) begin
                if (req_cnt >= ack_delay) begin
                    ack = 1'b1;
                    req_cnt = 0;
                end else begin
                    ack = 1'b0;
                    req_cnt++;
                end
            end else begin
                ack = 1'b0;
                req_cnt = 0;
            end
        end
    end

    task automatic issue_start(input logic [AW-1:0] b, input int dly);
        ack_delay = dly;
        @(negedge tb_clk);
        base  = b;
        start = 1'b1;
        @(posedge tb_clk);
        #1;
        st_base = b;
        st_edge = edge_n;
        st_tied = (dly == 0);
        start_seq++;
        start = 1'b0;
        base  = ~b;
    endtask

    task automatic run_load(input logic [AW-1:0] b, input int dly, input bit spur);
        int n;
        bit sw;
        issue_start(b, dly);
        n  = 0;
        sw = 1'b0;
        while (!done && n < 300) begin
            @(negedge tb_clk);
            n++;
            start = 1'b0;
            if (spur && set != 0 && !sw) begin
                start = 1'b1;
                sw    = 1'b1;
            end
        end
        check("done_seen", done, 1);
        if (spur) begin
            start = 1'b1;
            @(negedge tb_clk);
            start = 1'b0;
        end
        repeat (3) @(negedge tb_clk);
        check("one_done", m_dones, 1);
    endtask

    initial begin
        int n;
        rst   = 1'b0;
        start = 1'b0;
        base  = '0;
        #1 rst = 1'b1;
        #2;
        check("reset_state", {req, addr, set, wdata, clear, busy, done}, 32'd0);
        @(negedge tb_clk);
        #2 rst = 1'b0;
        repeat (2) @(negedge tb_clk);

        // Ack tied high, base 0x010.
        run_load(10'h010, 0, 1'b0);
        check("lit_wdata_first", wd_log[0], 8'h10);
        check("lit_wdata_last", wd_log[8], 8'h18);
        check("lit_latency", m_lat, CLR ? 20 : 19);

        // Ack delayed by three cycles per request.
        run_load(10'h100, 3, 1'b0);
        check("lit_delay_addr4", ad_log[4], 10'h104);

        // Start pulsed during a WRITE and during DONE.
        run_load(10'h050, 0, 1'b1);

        // Address wrap at the top of memory.
        run_load(10'h3FE, 0, 1'b0);
        check("lit_wrap_a0", ad_log[0], 10'h3FE);
        check("lit_wrap_a1", ad_log[1], 10'h3FF);
        check("lit_wrap_a2", ad_log[2], 10'h000);
        check("lit_wrap_a8", ad_log[8], 10'h006);
        check("lit_wrap_wd1", wd_log[1], 8'hFF);

        // Reset during the fifth WRITE, then a fresh load.
        issue_start(10'h020, 0);
        n = 0;
        while (!set[4] && n < 100) begin
            @(negedge tb_clk);
            n++;
        end
        check("reached_write5", set[4], 1);
        #2;
        rst = 1'b1;
        abort_seq++;
        #1;
        check("async_rst_outputs", {req, addr, set, wdata, clear, busy, done}, 32'd0);
        repeat (2) @(negedge tb_clk);
        #2 rst = 1'b0;
        repeat (4) @(negedge tb_clk);
        run_load(10'h030, 0, 1'b0);
        check("lit_reload_wd0", wd_log[0], 8'h30);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/wload_ctrl.md
WLOAD_CTRL -- requirements
Module: wload_ctrl

Interface
REQ-001 Parameter WLC_DATA_WIDTH, default 8, width of one weight word.
REQ-002 Parameter WLC_NUM_WREG, default 9, number of weight registers sequenced (3x3 kernel); range 2..32.
REQ-003 Parameter WLC_ADDR_WIDTH, default 10, weight memory address width.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset, with these ports:
- WLC_Clk  in  1  single clock; all state changes on its rising edge.
- WLC_Reset  in  1  asynchronous, active-high reset.
- WLC_Start  in  1  load request; sampled in IDLE only.
- WLC_Base_Addr  in  ADDR_W  first weight address; captured on accepted Start.
- WLC_Mem_Ack  in  1  read data valid on WLC_Mem_Data this cycle.
- WLC_Mem_Data  in  DATA_W  weight word from memory.
- WLC_Mem_Req  out  1  read request, held until acknowledged.
- WLC_Mem_Addr  out  ADDR_W  read address.
- WLC_Set  out  NUM_WREG  one-hot load strobe, bit i drives weight register i's Set.
- WLC_Wdata  out  DATA_W  shared data bus to all weight registers.
- WLC_Clear  out  1  clear strobe to all weight registers.
- WLC_Busy  out  1  high whenever state is not IDLE.
- WLC_Done  out  1  one-cycle completion pulse.

Function
REQ-005 FSM states SHALL be IDLE, CLEAR, REQ, WRITE, DONE; all outputs registered.
REQ-006 IDLE: WLC_Start=1 SHALL capture WLC_Base_Addr, set index=0, go to CLEAR (macro defined) or REQ (macro undefined).
REQ-007 CLEAR: WLC_Clear=1 for exactly one cycle, then REQ.
REQ-008 REQ: WLC_Mem_Req=1, WLC_Mem_Addr=base+index modulo 2^ADDR_W; stay in REQ until WLC_Mem_Ack=1.
REQ-009 On the REQ cycle with WLC_Mem_Ack=1, WLC_Wdata SHALL load WLC_Mem_Data and state SHALL go to WRITE.
REQ-010 WRITE: WLC_Set SHALL equal one-hot bit[index] for exactly one cycle, WLC_Wdata stable; then index=NUM_WREG-1 -> DONE, else index+1 -> REQ.
REQ-011 DONE: WLC_Done=1 for one cycle, then IDLE; WLC_Wdata holds the last weight.
REQ-012 Minimum cost per weight SHALL be 2 cycles; with Ack tied high and macro undefined, Done SHALL assert 2*NUM_WREG+1 cycles after the Start sample edge.
REQ-013 WLC_Start outside IDLE (including in DONE) SHALL be ignored; no queuing.
REQ-014 WLC_Mem_Ack outside REQ SHALL be ignored.
REQ-015 WLC_Set SHALL never have more than one bit high; WLC_Set and WLC_Clear SHALL never be high together.
REQ-016 Address arithmetic SHALL wrap silently (base 0x3FE, 9 weights -> 0x3FE,0x3FF,0x000..0x006).

Reset
REQ-017 WLC_Reset=1 SHALL immediately force IDLE, index=0, base=0, and all outputs to 0, independent of WLC_Clk.
REQ-018 Reset mid-load SHALL abort with no further Set pulses; no Done for the aborted load.

Configuration
REQ-019 Macro WLC_CLEAR_EN defined: CLEAR state present, total latency +1 cycle.
REQ-020 Macro WLC_CLEAR_EN undefined: CLEAR state absent, WLC_Clear tied to 0, IDLE goes directly to REQ.

Verification
REQ-021 Ack tied 1, base=0x010, data=addr low byte, macro off -> Set pulses bits 0..8 in order with Wdata 0x10..0x18, Done 19 cycles after Start.
REQ-022 Ack delayed 3 cycles per request -> Mem_Req held with stable Mem_Addr during the wait, Set only after Ack, Done after 9 weights.
REQ-023 Start pulsed during WRITE and during DONE -> ignored, exactly one Done, Busy low the cycle after Done.
REQ-024 base=0x3FE -> Mem_Addr sequence 0x3FE,0x3FF,0x000..0x006.
REQ-025 Reset asserted during 5th WRITE -> all outputs 0 asynchronously, no Done; new Start after release reloads from index 0.
REQ-026 Macro on -> single Clear pulse the cycle after Start, before first Mem_Req; Done 20 cycles after Start with Ack tied 1.
